// File: rtl/apb_uart_tx.sv
// APB-programmable UART transmitter: byte FIFO feeding an 8N1 serial shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module apb_uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RST   = 16'd867
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSELx,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Handshake: a transfer completes on the rising edge where PSELx & PENABLE are
    // both high; PREADY is always 1, so every access has zero wait states.
    logic       apb_wr;
    logic [1:0] addr;
    logic       wr_txdata, wr_status, wr_baud, wr_ctrl;

    assign apb_wr    = PSELx & PENABLE & PWRITE;
    assign addr      = PADDR[3:2];
    assign wr_txdata = apb_wr && (addr == 2'd0);
    assign wr_status = apb_wr && (addr == 2'd1);
    assign wr_baud   = apb_wr && (addr == 2'd2);
    assign wr_ctrl   = apb_wr && (addr == 2'd3);
    assign PREADY    = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level;
    logic [4:0]    level5;
    logic          full, empty, push, pop;
    logic [7:0]    fifo_head;

    logic          ovf_q, ovf_d;
    logic          tx_en_q, tx_en_d;
    logic [15:0]   baud_q, baud_d;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   div_q, div_d;
    logic [2:0]    idx_q, idx_d, idx_nxt;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          busy, start_frame;

    // Pointers carry one extra wrap bit so full and empty fall out of the difference.
    assign level     = wr_ptr_q - rd_ptr_q;
    assign level5    = 5'(level);
    assign full      = (level == PW'(FIFO_DEPTH));
    assign empty     = (level == '0);
    assign fifo_head = mem_q[rd_ptr_q[AW-1:0]];
    assign push      = wr_txdata && (!full || pop);
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // A set on the same edge as a write-1 clear wins.
    always_comb begin
        ovf_d   = ovf_q;
        tx_en_d = tx_en_q;
        baud_d  = baud_q;
        if (wr_status && PWDATA[3])       ovf_d   = 1'b0;
        if (wr_txdata && full && !pop)    ovf_d   = 1'b1;
        if (wr_ctrl)                      tx_en_d = PWDATA[0];
        if (wr_baud)                      baud_d  = PWDATA[15:0];
    end

    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= PWDATA[7:0];
    end

    assign start_frame = tx_en_q && !empty;
    assign idx_nxt     = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start_frame) begin
                    pop     = 1'b1;
                    data_d  = fifo_head;
                    div_d   = baud_q;
                    cnt_d   = baud_q;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    state_d = DATA;
                    cnt_d   = div_q;
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_q;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = data_q[idx_nxt];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_q == 16'd0) begin
                    state_d = STOP;
                    cnt_d   = div_q;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == 16'd0) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (start_frame) begin
                        pop     = 1'b1;
                        data_d  = fifo_head;
                        div_d   = baud_q;
                        cnt_d   = baud_q;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            tx_en_q  <= 1'b0;
            baud_q   <= BAUD_RST;
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            div_q    <= 16'd0;
            idx_q    <= 3'd0;
            data_q   <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            tx_en_q  <= tx_en_d;
            baud_q   <= baud_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
        end
    end

    // Reads are gated by reset so the bus sees zero while the block is held.
    always_comb begin
        PRDATA = 32'h0;
        if (PRESETn && PSELx && !PWRITE) begin
            case (addr)
                2'd1:    PRDATA = {23'd0, level5, ovf_q, busy, empty, full};
                2'd2:    PRDATA = {16'd0, baud_q};
                2'd3:    PRDATA = {31'd0, tx_en_q};
                default: PRDATA = 32'h0;
            endcase
        end
    end

endmodule
